// File: rtl/ram_pkg.sv
// Shared definitions for the asymmetric dual-port RAM and its read/write sides.
// Holds RAM width/depth defaults, the read-controller state enum and the beats helper.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH_DEF = 5;
    localparam int RAM_WR_WIDTH_DEF   = 8;
    localparam int RAM_RD_WIDTH_DEF   = 32;
    localparam int RAM_RD_IND_DEF     = RAM_RD_WIDTH_DEF / RAM_WR_WIDTH_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND,
        ST_FIN
    } rd_state_t;

    // Number of output beats carried by one wide RAM word.
    function automatic int beats_of(input int rd_w, input int out_w);
        return rd_w / out_w;
    endfunction

endpackage

// File: rtl/ram_rd_unpack_word_serializer.sv
// word_serializer: loads one wide word and emits it as OUT_WIDTH beats on valid/ready.
// Ports: clk, rst_n, load, load_data, m_ready in; m_data, m_valid, last_beat out.
// Beat order: LSB beat first, or MSB beat first with RAM_RD_UNPACK_MSB_FIRST_EN.
module word_serializer
    import ram_pkg::*;
#(
    parameter int RD_WIDTH  = RAM_RD_WIDTH_DEF,
    parameter int OUT_WIDTH = RAM_WR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [RD_WIDTH-1:0]  load_data,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 last_beat
);

    localparam int BEATS = beats_of(RD_WIDTH, OUT_WIDTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [RD_WIDTH-1:0] shreg;
    logic [BW-1:0]       beat_cnt;
    logic                accept;

    assign accept    = m_valid & m_ready;
    assign last_beat = accept && (beat_cnt == BW'(BEATS - 1));

`ifdef RAM_RD_UNPACK_MSB_FIRST_EN
    assign m_data = shreg[RD_WIDTH-1 -: OUT_WIDTH];
`else
    assign m_data = shreg[OUT_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            beat_cnt <= '0;
            m_valid  <= 1'b0;
        end else if (load) begin
            shreg    <= load_data;
            beat_cnt <= '0;
            m_valid  <= 1'b1;
        end else if (accept) begin
`ifdef RAM_RD_UNPACK_MSB_FIRST_EN
            shreg <= shreg << OUT_WIDTH;
`else
            shreg <= shreg >> OUT_WIDTH;
`endif
            if (last_beat) begin
                beat_cnt <= '0;
                m_valid  <= 1'b0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_rd_unpack.sv
// Read-side controller: issues a burst of wide RAM reads and unpacks each word into beats.
// Ports: rd_clk, rd_rst_n, start, base_addr, word_cnt, rd_data, m_ready in;
// rd_addr, m_data, m_valid, busy, done out. Beat order macro: RAM_RD_UNPACK_MSB_FIRST_EN.
module ram_rd_unpack
    import ram_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int RD_WIDTH       = RAM_RD_WIDTH_DEF,
    parameter int OUT_WIDTH      = RAM_WR_WIDTH_DEF,
    parameter int RD_IND         = RAM_RD_IND_DEF,
    parameter int CNT_WIDTH      = 6
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]      word_cnt,
    output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [RD_WIDTH-1:0]       rd_data,
    output logic [OUT_WIDTH-1:0]      m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      done
);

    rd_state_t            state_q;
    rd_state_t            state_d;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 last_beat;
    logic                 load;

    // RAM output is valid during WAIT, so the word is captured as WAIT ends.
    assign load = (state_q == ST_WAIT);
    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (word_cnt != '0) ? ST_ISSUE : ST_FIN;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_SEND;
            ST_SEND: begin
                if (last_beat) begin
                    state_d = (remaining != '0) ? ST_ISSUE : ST_FIN;
                end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // done is registered so it lands the cycle after FIN.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_addr   <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state_q == ST_FIN);
            if (state_q == ST_IDLE && start) begin
                rd_addr   <= base_addr;
                remaining <= word_cnt;
            end else if (state_q == ST_WAIT) begin
                rd_addr   <= rd_addr + RAM_ADDR_WIDTH'(RD_IND);
                remaining <= remaining - 1'b1;
            end
        end
    end

    word_serializer #(
        .RD_WIDTH  (RD_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_ser (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .load      (load),
        .load_data (rd_data),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .last_beat (last_beat)
    );

endmodule

// File: tb/tb_ram_rd_unpack.sv
// Bench for ram_rd_unpack: byte RAM model with registered 32-bit read,
// expected beats queued at start and popped at each accepted beat.
module tb_ram_rd_unpack;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  word_cnt;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:31];
    logic [7:0]  exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          n_acc  = 0;
    bit          stalled = 1'b0;
    logic [7:0]  held;

    ram_rd_unpack dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 rd_clk = ~rd_clk;

    // Registered RAM read: little-endian packing of four byte cells.
    always @(posedge rd_clk) begin
        rd_data <= {mem[rd_addr + 5'd3], mem[rd_addr + 5'd2],
                    mem[rd_addr + 5'd1], mem[rd_addr]};
    end

    // Scoreboard monitor: inputs settle after posedge, so at negedge
    // valid&ready means the beat is taken at the next posedge.
    always @(negedge rd_clk) begin
        logic [7:0] e;
        if (!rd_rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h",
                             m_valid, m_data, held);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                n_acc++;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_extra: got %h with no beat expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL beat_data: got %h required %h", m_data, e);
                    end
                end
            end else if (m_valid) begin
                stalled = 1'b1;
                held    = m_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_burst(input logic [4:0] base, input int cnt);
        logic [4:0] a;
        logic [4:0] idx;
        for (int w = 0; w < cnt; w++) begin
            a = base + 5'(4 * w);
            for (int b = 0; b < 4; b++) begin
`ifdef RAM_RD_UNPACK_MSB_FIRST_EN
                idx = a + 5'(3 - b);
`else
                idx = a + 5'(b);
`endif
                exp_q.push_back(mem[idx]);
            end
        end
    endtask

    task automatic test_reset;
        rd_rst_n = 1'b0;
        repeat (3) tick;
        checks++;
        if (rd_addr !== 5'd0 || m_data !== 8'd0 || m_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: addr=%h data=%h valid=%b busy=%b done=%b required all 0",
                     rd_addr, m_data, m_valid, busy, done);
        end
        rd_rst_n = 1'b1;
        repeat (2) tick;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy, m_valid);
        end
    endtask

    task automatic test_basic;
        int ndone = 0;
        int dcyc = -1;
        tick;
        n_acc = 0;
        m_ready = 1'b1;
        push_burst(5'd0, 2);
        start = 1'b1; base_addr = 5'd0; word_cnt = 6'd2;
        for (int c = 1; c <= 20; c++) begin
            tick;
            start = 1'b0;
            @(negedge rd_clk);
            if (c == 1) begin
                checks++;
                if (rd_addr !== 5'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_issue0: addr=%h busy=%b required 00 1", rd_addr, busy);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (m_valid !== (c == 3)) begin
                    errors++;
                    $display("FAIL basic_latency c%0d: valid=%b required %b", c, m_valid, c == 3);
                end
            end
            if (c == 7) begin
                checks++;
                if (rd_addr !== 5'd4) begin
                    errors++;
                    $display("FAIL basic_issue1: addr=%h required 04", rd_addr);
                end
            end
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
        end
        checks++;
        if (ndone != 1 || dcyc != 14) begin
            errors++;
            $display("FAIL basic_done: pulses=%0d cycle=%0d required 1 at 14", ndone, dcyc);
        end
        checks++;
        if (n_acc != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: beats=%0d left=%0d required 8 0", n_acc, exp_q.size());
        end
    endtask

    task automatic test_wrap;
        tick;
        n_acc = 0;
        m_ready = 1'b1;
        push_burst(5'd28, 2);
        start = 1'b1; base_addr = 5'd28; word_cnt = 6'd2;
        for (int c = 1; c <= 16; c++) begin
            tick;
            start = 1'b0;
            @(negedge rd_clk);
            if (c == 1 || c == 7) begin
                checks++;
                if (rd_addr !== ((c == 1) ? 5'd28 : 5'd0)) begin
                    errors++;
                    $display("FAIL wrap_addr c%0d: addr=%0d required %0d",
                             c, rd_addr, (c == 1) ? 28 : 0);
                end
            end
        end
        checks++;
        if (n_acc != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_count: beats=%0d left=%0d required 8 0", n_acc, exp_q.size());
        end
    endtask

    task automatic test_zero;
        int dcyc = -1;
        int ndone = 0;
        bit mv = 1'b0;
        tick;
        m_ready = 1'b1;
        start = 1'b1; base_addr = 5'd9; word_cnt = 6'd0;
        for (int c = 1; c <= 6; c++) begin
            tick;
            start = 1'b0;
            @(negedge rd_clk);
            if (m_valid) mv = 1'b1;
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
        end
        checks++;
        if (ndone != 1 || dcyc != 2) begin
            errors++;
            $display("FAIL zero_done: pulses=%0d cycle=%0d required 1 at 2", ndone, dcyc);
        end
        checks++;
        if (mv !== 1'b0 || rd_addr !== 5'd9) begin
            errors++;
            $display("FAIL zero_quiet: valid_seen=%b addr=%0d required 0 9", mv, rd_addr);
        end
    endtask

    task automatic test_stall;
        bit seen = 1'b0;
        tick;
        n_acc = 0;
        push_burst(5'd4, 3);
        start = 1'b1; base_addr = 5'd4; word_cnt = 6'd3;
        m_ready = 1'b1;
        for (int c = 1; c <= 300 && !seen; c++) begin
            tick;
            start = 1'b0;
            m_ready = 1'($urandom_range(0, 1));
            @(negedge rd_clk);
            if (done) seen = 1'b1;
        end
        m_ready = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_timeout: done=0 required 1 within 300 cycles");
        end
        checks++;
        if (n_acc != 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_count: beats=%0d left=%0d required 12 0", n_acc, exp_q.size());
        end
    endtask

    task automatic test_start_busy;
        int dcyc = -1;
        tick;
        n_acc = 0;
        m_ready = 1'b1;
        push_burst(5'd0, 1);
        start = 1'b1; base_addr = 5'd0; word_cnt = 6'd1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            start     = (c == 4);
            base_addr = (c == 4) ? 5'd16 : 5'd0;
            word_cnt  = (c == 4) ? 6'd5 : 6'd1;
            @(negedge rd_clk);
            if (done && dcyc < 0) dcyc = c;
        end
        start = 1'b0;
        checks++;
        if (dcyc != 8 || rd_addr !== 5'd4) begin
            errors++;
            $display("FAIL busy_start: done_cycle=%0d addr=%0d required 8 4", dcyc, rd_addr);
        end
        checks++;
        if (n_acc != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_count: beats=%0d left=%0d required 4 0", n_acc, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        tick;
        n_acc = 0;
        m_ready = 1'b1;
        push_burst(5'd0, 2);
        start = 1'b1; base_addr = 5'd0; word_cnt = 6'd2;
        for (int c = 1; c <= 10; c++) begin
            tick;
            start = 1'b0;
            @(negedge rd_clk);
        end
        tick;
        rd_rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== 5'd0 ||
            m_data !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b addr=%h data=%h done=%b required all 0",
                     m_valid, busy, rd_addr, m_data, done);
        end
        exp_q.delete();
        tick;
        rd_rst_n = 1'b1;
        tick;
        n_acc = 0;
        push_burst(5'd8, 1);
        start = 1'b1; base_addr = 5'd8; word_cnt = 6'd1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            start = 1'b0;
            @(negedge rd_clk);
            if (done) ndone++;
        end
        checks++;
        if (n_acc != 4 || exp_q.size() != 0 || ndone != 1) begin
            errors++;
            $display("FAIL mid_restart: beats=%0d left=%0d done=%0d required 4 0 1",
                     n_acc, exp_q.size(), ndone);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 8'(k);
        rd_rst_n  = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        word_cnt  = '0;
        m_ready   = 1'b0;
        test_reset;
        test_basic;
        test_wrap;
        test_zero;
        test_stall;
        test_start_busy;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_rd_unpack.md
Name: ram_rd_unpack

Overview:
- Read-side controller for the asymmetric dual-port RAM (8-bit write, 32-bit read).
- Generates `rd_addr` for a programmed burst of wide RAM words.
- Captures each `RD_WIDTH` read word and serialises it into `OUT_WIDTH` beats on a valid/ready stream.
- Lives entirely in the read clock domain. It is the consumer counterpart of the narrow-write stream that fills the RAM.

Parameters:
- RAM_ADDR_WIDTH, 5: RAM address width; all address arithmetic is modulo 2^RAM_ADDR_WIDTH.
- RD_WIDTH, 32: RAM read data width.
- OUT_WIDTH, 8: output beat width. RD_WIDTH must be an integer multiple of OUT_WIDTH.
- RD_IND, 4: address increment per RAM read (RAM cells per read word).
- BEATS, RD_WIDTH/OUT_WIDTH: beats per word; local, not overridable.
- CNT_WIDTH, 6: width of `word_cnt`.

Ports:
- rd_clk  in  1  read-domain clock, rising edge.
- rd_rst_n  in  1  asynchronous active-low reset, synchronous deassertion assumed upstream.
- start  in  1  one-cycle request to begin a burst; ignored unless IDLE.
- base_addr  in  RAM_ADDR_WIDTH  first RAM read address; sampled with `start`.
- word_cnt  in  CNT_WIDTH  number of RAM words to read; sampled with `start`.
- rd_addr  out  RAM_ADDR_WIDTH  registered RAM read address.
- rd_data  in  RD_WIDTH  RAM read data, valid the cycle after `rd_addr` is sampled by the RAM.
- m_data  out  OUT_WIDTH  output beat.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accept.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (asynchronous, `rd_rst_n`=0):
  - outputs: `rd_addr`=0, `m_data`=0, `m_valid`=0, `busy`=0, `done`=0;
  - state IDLE; internal counters 0.
- States: IDLE, ISSUE, WAIT, SEND, FIN.
- IDLE:
  - on `start`=1, latch `base_addr` into `rd_addr` and `word_cnt` into the remaining-word counter;
  - go to ISSUE if `word_cnt`≠0, else go to FIN.
- ISSUE (1 cycle): `rd_addr` is stable; the RAM registers it at the end of this cycle. Next state WAIT.
- WAIT (1 cycle):
  - capture `rd_data` into the shift register at the end of this cycle;
  - decrement the remaining-word counter;
  - advance `rd_addr` by `RD_IND` (wraps modulo 2^RAM_ADDR_WIDTH);
  - next state SEND.
- SEND:
  - `m_valid`=1, and `m_data` = current beat;
  - a beat is accepted when `m_valid` & `m_ready`; on acceptance the shift register advances one beat and the beat counter increments;
  - `m_data` and `m_valid` hold stable while `m_ready`=0; valid is never withdrawn before acceptance;
  - on acceptance of beat `BEATS`-1: go to ISSUE if remaining>0, else go to FIN; `m_valid` drops the next cycle.
- FIN (1 cycle): `done`=1, `busy`=0 next cycle, return to IDLE.
- Latency: first beat has `m_valid` 3 cycles after the `start` cycle (ISSUE, WAIT, then SEND).
- Throughput: steady state is BEATS+2 cycles per word with `m_ready` held high.
- Boundary cases:
  - `word_cnt`=0: `done` pulses 2 cycles after `start`; no reads issued, no beats.
  - `start` while busy: ignored; the latched parameters are unaffected.
  - address wrap: `base_addr`=28 with `RD_IND`=4 gives reads at 28, then 0.
  - reset mid-burst: immediate return to IDLE with all outputs at reset values; the partial word is discarded.
  - `m_ready` high during ISSUE/WAIT has no effect.

Optional Feature:
- Macro: RAM_RD_UNPACK_MSB_FIRST_EN.
- Defined: beat 0 = `rd_data[RD_WIDTH-1 -: OUT_WIDTH]`; the shift register shifts left.
- Undefined (default): beat 0 = `rd_data[OUT_WIDTH-1:0]`; the shift register shifts right.
- Either way, the macro only changes ordering; timing and handshake are identical.

Decomposition:
- Shared package `ram_pkg`:
  - state enum;
  - RAM width/depth defaults shared with the RAM and the write side;
  - the BEATS derivation function.
- One natural sub-module, `word_serializer`:
  - contents: load, shift register, beat counter, valid/ready logic;
  - interface: signals `last_beat`.
- The FSM and address generator stay in `ram_rd_unpack`.

Test Plan:
1. RAM bytes 0x00..0x07 at addr 0..7; `start`, base 0, cnt 2, `m_ready`=1 → `m_data` 00,01,…,07 over 8 accepted beats; `rd_addr` 0 then 4; single `done`.
2. Same stimulus with the macro defined → beats 03,02,01,00,07,06,05,04.
3. `m_ready` toggled 1-0-0-1 pseudo-randomly during SEND → no beat lost or duplicated; `m_data` stable while stalled.
4. base 28, cnt 2, byte k at addr k → reads at 28 then 0; beats 1C,1D,1E,1F,00,01,02,03.
5. cnt 0 → `done` 2 cycles after `start`; `m_valid` never asserted; `rd_addr` = `base_addr`.
6. Assert `rd_rst_n`=0 during beat 2 of word 1 → `m_valid`/`busy` drop to 0 immediately; a new `start` (base 8, cnt 1) afterwards yields bytes 08..0B.
